// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA widths, arbiter state encoding and colour constants
package vga_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] WHITE = 3'b111;
  localparam logic [COL_W-1:0] RED   = 3'b100;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts at ptr+1 and wraps
module rr_pick
  import vga_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  // Offset k is the distance from the pointer; the first hit in distance order wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any_o && req_i[i] && (i == (int'(ptr_i) + k) % N)) begin
          any_o    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/vga_pixel_arbiter.sv
// rtl/vga_pixel_arbiter.sv - round-robin arbiter sharing the VGA pixel-write port
module vga_pixel_arbiter
  import vga_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       lock,
  input  logic [X_W*N-1:0]   x_in,
  input  logic [Y_W*N-1:0]   y_in,
  input  logic [COL_W*N-1:0] colour_in,
  output logic [N-1:0]       ack,
  output logic [ID_W-1:0]    gnt_id,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COL_W-1:0]   colour,
  output logic               writeEn,
  output logic               busy
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [COL_W-1:0]  colour_q;
  logic              we_q;

  logic [N-1:0]      pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [N-1:0]      owner_mask;
  logic              others_req;
  logic              at_max;
  logic              preempt;
  logic              xfer;
  logic [X_W-1:0]    x_sel;
  logic [Y_W-1:0]    y_sel;
  logic [COL_W-1:0]  colour_sel;

  rr_pick #(.N(N)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign owner_mask = N'(1) << owner_q;
  assign others_req = |(req & ~owner_mask);
  assign at_max     = (hold_cnt_q == HOLD_W'(MAX_HOLD));
  assign preempt    = (state_q == OWNED) && at_max && others_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      we_q       <= xfer;
      if (xfer) begin
        x_q      <= x_sel;
        y_q      <= y_sel;
        colour_q <= colour_sel;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    if (xfer) rr_ptr_d = gnt_id;
    case (state_q)
      IDLE: begin
        if (pick_any && |(lock & pick_gnt)) begin
          state_d    = OWNED;
          owner_d    = pick_idx;
          hold_cnt_d = HOLD_W'(1);
        end
      end
      OWNED: begin
        // Pointer parked on the owner so the next IDLE search skips it.
        if (preempt) begin
          state_d    = IDLE;
          rr_ptr_d   = owner_q;
          hold_cnt_d = '0;
        end else if (!(|(lock & owner_mask))) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else if (xfer && !at_max) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack    = '0;
    gnt_id = '0;
    case (state_q)
      IDLE: begin
        ack    = pick_gnt;
        gnt_id = pick_idx;
      end
      OWNED: begin
        if (!preempt && |(req & owner_mask)) begin
          ack    = owner_mask;
          gnt_id = owner_q;
        end
      end
      default: ack = '0;
    endcase
  end

  assign xfer = |ack;

  always_comb begin
    x_sel      = '0;
    y_sel      = '0;
    colour_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        x_sel      = x_in[i*X_W +: X_W];
        y_sel      = y_in[i*Y_W +: Y_W];
        colour_sel = colour_in[i*COL_W +: COL_W];
      end
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign writeEn = we_q;
  assign busy    = (state_q == OWNED);

endmodule
